// File: rtl/pc_fetch_unit_if.sv
// Handshake bundle between the PC fetch stage and its neighbours (selector, EX targets, hazard unit).
interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [1:0]        pc_src;
  logic [ADDR_W-1:0] target_b;
  logic [ADDR_W-1:0] target_jalr;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              flush_ifid;
  logic              flush_idex;
  logic              halted;

  modport master (
    output pc_src, target_b, target_jalr, stall,
    input  pc, pc_plus4, flush_ifid, flush_idex, halted
  );

  modport slave (
    input  pc_src, target_b, target_jalr, stall,
    output pc, pc_plus4, flush_ifid, flush_idex, halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch stage: next-PC select, stall hold, redirect flushes, misaligned-target halt trap.
// Optional statistics counters are enabled by defining PC_FETCH_STATS_EN.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.slave  bus
`ifdef PC_FETCH_STATS_EN
  ,
  output logic [15:0]     redirect_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] sel_target;
  logic              redirect;
  logic              aligned;
  logic              flush;

  always_comb begin
    redirect   = (bus.pc_src == 2'b01) || (bus.pc_src == 2'b10);
    sel_target = (bus.pc_src == 2'b10) ? bus.target_jalr : bus.target_b;
    aligned    = (sel_target[1:0] == 2'b00);
  end

  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    case (state_q)
      S_RUN: begin
        // A redirect beats a stall; a misaligned one traps with pc frozen.
        if (redirect) begin
          flush = 1'b1;
          if (aligned) begin
            pc_d = sel_target;
          end else begin
            state_d = S_HALT;
          end
        end else if (!bus.stall) begin
          pc_d = pc_plus4;
        end
      end
      S_HALT: begin
        flush = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    if (rst) begin
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.flush_ifid = flush;
  assign bus.flush_idex = flush;
  assign bus.halted     = (state_q == S_HALT);

`ifdef PC_FETCH_STATS_EN
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (state_q == S_RUN) begin
      if (redirect && aligned && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
      if (!redirect && bus.stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reference model compared every negedge plus literal checkpoints.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(32)) bus ();

`ifdef PC_FETCH_STATS_EN
  logic [15:0] redirect_cnt, stall_cnt;
`endif

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PC_FETCH_STATS_EN
    ,
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // Reference model: architectural PC, trap flag and event counts.
  logic [31:0] m_pc;
  logic        m_halt;
  logic [15:0] m_rc, m_sc;

  function automatic logic is_redirect(input logic [1:0] s);
    return (s == 2'd1) || (s == 2'd2);
  endfunction

  function automatic logic [31:0] target_of(input logic [1:0] s, input logic [31:0] b, input logic [31:0] j);
    return (s == 2'd2) ? j : b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc   <= RST_PC;
      m_halt <= 1'b0;
      m_rc   <= 16'd0;
      m_sc   <= 16'd0;
    end else if (!m_halt) begin
      if (is_redirect(bus.pc_src)) begin
        if ((target_of(bus.pc_src, bus.target_b, bus.target_jalr) % 4) == 0) begin
          m_pc <= target_of(bus.pc_src, bus.target_b, bus.target_jalr);
          m_rc <= (m_rc == 16'hFFFF) ? m_rc : m_rc + 16'd1;
        end else begin
          m_halt <= 1'b1;
        end
      end else if (bus.stall) begin
        m_sc <= (m_sc == 16'hFFFF) ? m_sc : m_sc + 16'd1;
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model whenever out of reset.
  always @(negedge clk) begin
    logic exp_flush;
    if (!rst) begin
      exp_flush = m_halt ? 1'b1 : is_redirect(bus.pc_src);
      chk("m_pc", bus.pc, m_pc);
      chk("m_pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      chk("m_flush_ifid", {31'd0, bus.flush_ifid}, {31'd0, exp_flush});
      chk("m_flush_idex", {31'd0, bus.flush_idex}, {31'd0, exp_flush});
      chk("m_halted", {31'd0, bus.halted}, {31'd0, m_halt});
`ifdef PC_FETCH_STATS_EN
      chk("m_redirect_cnt", {16'd0, redirect_cnt}, {16'd0, m_rc});
      chk("m_stall_cnt", {16'd0, stall_cnt}, {16'd0, m_sc});
`endif
    end
  end

  task automatic drive(input logic [1:0] s, input logic [31:0] b, input logic [31:0] j, input logic st);
    bus.pc_src      = s;
    bus.target_b    = b;
    bus.target_jalr = j;
    bus.stall       = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("[TB] t=%0t pc=%h halted=%0b flush=%0b", $time, bus.pc, bus.halted, bus.flush_ifid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(2'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    rst = 1'b0;

    // Sequential fetch from reset PC
    tick(); chk("seq_104", bus.pc, 32'h104);
    tick(); chk("seq_108", bus.pc, 32'h108);
    tick(); chk("seq_10c", bus.pc, 32'h10C);
    chk("seq_noflush", {31'd0, bus.flush_ifid}, 32'd0);

    // Branch to 0x10, then 0x10 -> 0x40
    drive(2'd1, 32'h10, 32'd0, 1'b0);
    tick(); chk("br_10", bus.pc, 32'h10);
    drive(2'd1, 32'h40, 32'd0, 1'b0);
    chk("br_flush_ifid", {31'd0, bus.flush_ifid}, 32'd1);
    chk("br_flush_idex", {31'd0, bus.flush_idex}, 32'd1);
    tick(); chk("br_40", bus.pc, 32'h40);
    drive(2'd0, 32'd0, 32'd0, 1'b0);
    chk("br_flush_clear", {31'd0, bus.flush_idex}, 32'd0);

    // jalr to 0x20, stall two cycles
    drive(2'd2, 32'd0, 32'h20, 1'b0);
    tick(); chk("jalr_20", bus.pc, 32'h20);
    drive(2'd0, 32'd0, 32'd0, 1'b1);
    chk("stall_noflush", {31'd0, bus.flush_ifid}, 32'd0);
    tick(); chk("stall_hold1", bus.pc, 32'h20);
    tick(); chk("stall_hold2", bus.pc, 32'h20);
    drive(2'd0, 32'd0, 32'd0, 1'b0);
    tick(); chk("stall_release", bus.pc, 32'h24);
`ifdef PC_FETCH_STATS_EN
    chk("stall_cnt_2", {16'd0, stall_cnt}, 32'd2);
`endif

    // Redirect together with stall: redirect wins
    drive(2'd2, 32'd0, 32'h80, 1'b1);
    chk("rs_flush", {31'd0, bus.flush_ifid}, 32'd1);
    tick(); chk("rs_80", bus.pc, 32'h80);
`ifdef PC_FETCH_STATS_EN
    chk("rs_redirect_cnt", {16'd0, redirect_cnt}, 32'd4);
    chk("rs_stall_cnt", {16'd0, stall_cnt}, 32'd2);
`endif

    // Wrap-around with reserved selector
    drive(2'd1, 32'hFFFF_FFFC, 32'd0, 1'b0);
    tick(); chk("wrap_top", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.pc_plus4, 32'h0);
    drive(2'd3, 32'h0000_0002, 32'h0000_0006, 1'b0);
    chk("res_noflush", {31'd0, bus.flush_idex}, 32'd0);
    tick(); chk("wrap_pc0", bus.pc, 32'h0);
    chk("wrap_pc4", bus.pc_plus4, 32'h4);

    // Misaligned redirect traps
    drive(2'd1, 32'h30, 32'd0, 1'b0);
    tick(); chk("pre_trap_30", bus.pc, 32'h30);
    drive(2'd1, 32'h42, 32'd0, 1'b0);
    chk("mis_flush", {31'd0, bus.flush_ifid}, 32'd1);
    tick(); chk("trap_halted", {31'd0, bus.halted}, 32'd1);
    chk("trap_pc", bus.pc, 32'h30);
    drive(2'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_pc", bus.pc, 32'h30);
      chk("halt_flush", {31'd0, bus.flush_idex}, 32'd1);
    end
`ifdef PC_FETCH_STATS_EN
    chk("halt_redirect_cnt", {16'd0, redirect_cnt}, 32'd6);
`endif

    // Asynchronous reset mid-cycle, with a redirect present that must be ignored
    drive(2'd1, 32'h40, 32'd0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc, RST_PC);
    chk("arst_halted", {31'd0, bus.halted}, 32'd0);
    chk("arst_flush", {31'd0, bus.flush_ifid}, 32'd0);
    @(posedge clk);
    #1;
    drive(2'd0, 32'd0, 32'd0, 1'b1);
    rst = 1'b0;
    tick(); chk("post_rst_stall", bus.pc, RST_PC);
    drive(2'd0, 32'd0, 32'd0, 1'b0);
    tick(); chk("post_rst_seq", bus.pc, RST_PC + 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
